uart_cmd_parser: RTL and testbench

ASCII command parser between the UART receive FIFO and the UART transmitter. It pops received bytes from the FIFO, decodes short line-terminated commands that override the RGB LED pattern or set the rotation period, and returns a one-byte acknowledge through the transmitter. It replaces the direct FIFO-to-TX loopback in the top level; the LED rotator consumes its outputs.

---
 rtl/uart_cmd_pkg.sv | 38 +++
 rtl/ascii_hex_decode.sv | 21 ++
 rtl/uart_cmd_parser.sv | 166 ++++++++++++++++
 tb/tb_uart_cmd_parser.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared types and character codes for the UART command parser.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARG1,
    ST_ARG2,
    ST_TERM_WAIT,
    ST_DISCARD,
    ST_REPLY
  } state_e;

  typedef enum logic [1:0] {
    CMD_L,
    CMD_P,
    CMD_R
  } cmd_e;

  localparam logic [7:0] CHAR_LF = 8'h0A;
  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_L  = 8'h6C;  // lower-case letter codes, matched after folding
  localparam logic [7:0] CHAR_P  = 8'h70;
  localparam logic [7:0] CHAR_R  = 8'h72;

  localparam logic [7:0] ACK_DEFAULT    = 8'h4B;
  localparam logic [7:0] NAK_DEFAULT    = 8'h45;
  localparam logic [7:0] PERIOD_DEFAULT = 8'd24;

  function automatic logic is_term(input logic [7:0] c);
    return (c == CHAR_LF) || (c == CHAR_CR);
  endfunction

  // Setting bit 5 lower-cases a letter; only 0x4C/0x6C fold onto 'l' (same for p, r).
  function automatic logic [7:0] fold_case(input logic [7:0] c);
    return c | 8'h20;
  endfunction

endpackage

// File: rtl/ascii_hex_decode.sv
// Combinational ASCII hex digit decoder: 0-9, A-F, a-f to a nibble.
module ascii_hex_decode (
  input  logic [7:0] ch_i,
  output logic       valid_o,
  output logic [3:0] nibble_o
);

  always_comb begin
    valid_o  = 1'b0;
    nibble_o = 4'h0;
    if (ch_i >= 8'h30 && ch_i <= 8'h39) begin
      valid_o  = 1'b1;
      nibble_o = ch_i[3:0];
    end else if ((ch_i >= 8'h41 && ch_i <= 8'h46) || (ch_i >= 8'h61 && ch_i <= 8'h66)) begin
      // 'A'/'a' have low nibble 1, so adding 9 yields 10..15
      valid_o  = 1'b1;
      nibble_o = ch_i[3:0] + 4'd9;
    end
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// Decodes line-terminated L/P/R commands from the RX FIFO and replies K/E via the TX.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0] DEFAULT_PERIOD = PERIOD_DEFAULT,
  parameter logic [7:0] ACK_CHAR       = ACK_DEFAULT,
  parameter logic [7:0] NAK_CHAR       = NAK_DEFAULT
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       rx_empty,
  input  logic [7:0] rx_data,
  output logic       rx_re,
  input  logic       tx_busy,
  output logic       tx_en,
  output logic [7:0] tx_data,
  output logic       led_override,
  output logic [2:0] led_value,
  output logic [7:0] period,
  output logic [7:0] err_cnt,
  output logic [2:0] dbg_state_o
);

  state_e     state_q;
  cmd_e       cmd_q;
  logic [7:0] arg_q;
  logic       tx_en_q;
  logic [7:0] tx_data_q;
  logic       led_override_q;
  logic [2:0] led_value_q;
  logic [7:0] period_q;
  logic [7:0] err_cnt_q;

  logic       hex_valid;
  logic [3:0] hex_nib;
  logic       is_term_w;
  logic       zero_period;
  logic       ack_fire;
  logic       nak_fire;

  ascii_hex_decode u_hex (
    .ch_i     (rx_data),
    .valid_o  (hex_valid),
    .nibble_o (hex_nib)
  );

  // Handshake: a byte is consumed in any cycle where rx_re is high; rx_data is
  // valid whenever rx_empty is low. tx_en is a one-cycle request, only issued
  // after a cycle in which tx_busy was low.
  assign rx_re       = !rx_empty && (state_q != ST_REPLY);
  assign is_term_w   = is_term(rx_data);
  assign zero_period = (cmd_q == CMD_P) && (arg_q == 8'h00);

  always_comb begin
    ack_fire = 1'b0;
    nak_fire = 1'b0;
    if (rx_re && is_term_w) begin
      case (state_q)
        ST_ARG1, ST_ARG2, ST_DISCARD: nak_fire = 1'b1;
        ST_TERM_WAIT: begin
          nak_fire = zero_period;
          ack_fire = !zero_period;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      cmd_q          <= CMD_R;
      arg_q          <= 8'h00;
      tx_en_q        <= 1'b0;
      tx_data_q      <= 8'h00;
      led_override_q <= 1'b0;
      led_value_q    <= 3'b000;
      period_q       <= DEFAULT_PERIOD;
      err_cnt_q      <= 8'h00;
    end else begin
      tx_en_q <= 1'b0;

      if (ack_fire) begin
        tx_data_q <= ACK_CHAR;
        case (cmd_q)
          CMD_L: begin
            led_override_q <= 1'b1;
            led_value_q    <= arg_q[2:0];
          end
          CMD_P:   period_q       <= arg_q;
          default: led_override_q <= 1'b0;
        endcase
      end

      if (nak_fire) begin
        tx_data_q <= NAK_CHAR;
        if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
      end

      if (state_q == ST_REPLY) begin
        if (!tx_busy) begin
          tx_en_q <= 1'b1;
          state_q <= ST_IDLE;
        end
      end else if (rx_re) begin
        if (ack_fire || nak_fire) begin
          state_q <= ST_REPLY;
        end else begin
          case (state_q)
            ST_IDLE: begin
              if (is_term_w) begin
                state_q <= ST_IDLE;
              end else if (fold_case(rx_data) == CHAR_L) begin
                cmd_q   <= CMD_L;
                state_q <= ST_ARG1;
              end else if (fold_case(rx_data) == CHAR_P) begin
                cmd_q   <= CMD_P;
                state_q <= ST_ARG1;
              end else if (fold_case(rx_data) == CHAR_R) begin
                cmd_q   <= CMD_R;
                state_q <= ST_TERM_WAIT;
              end else begin
                state_q <= ST_DISCARD;
              end
            end
            ST_ARG1: begin
              if (hex_valid && cmd_q == CMD_L) begin
                if (!hex_nib[3]) begin
                  arg_q   <= {4'h0, hex_nib};
                  state_q <= ST_TERM_WAIT;
                end else begin
                  state_q <= ST_DISCARD;
                end
              end else if (hex_valid) begin
                arg_q[7:4] <= hex_nib;
                state_q    <= ST_ARG2;
              end else begin
                state_q <= ST_DISCARD;
              end
            end
            ST_ARG2: begin
              if (hex_valid) begin
                arg_q[3:0] <= hex_nib;
                state_q    <= ST_TERM_WAIT;
              end else begin
                state_q <= ST_DISCARD;
              end
            end
            ST_TERM_WAIT: state_q <= ST_DISCARD;
            ST_DISCARD:   state_q <= ST_DISCARD;
            default:      state_q <= ST_IDLE;
          endcase
        end
      end
    end
  end

  assign tx_en        = tx_en_q;
  assign tx_data      = tx_data_q;
  assign led_override = led_override_q;
  assign led_value    = led_value_q;
  assign period       = period_q;
  assign err_cnt      = err_cnt_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: directed cases plus random command lines.
module tb_uart_cmd_parser;

  logic       clk_in   = 1'b0;
  logic       rst_n    = 1'b0;
  logic       rx_empty = 1'b1;
  logic [7:0] rx_data  = 8'h00;
  logic       rx_re;
  logic       tx_busy  = 1'b0;
  logic       tx_en;
  logic [7:0] tx_data;
  logic       led_override;
  logic [2:0] led_value;
  logic [7:0] period;
  logic [7:0] err_cnt;
  logic [2:0] dbg_state;

  uart_cmd_parser dut (
    .clk_in       (clk_in),
    .rst_n        (rst_n),
    .rx_empty     (rx_empty),
    .rx_data      (rx_data),
    .rx_re        (rx_re),
    .tx_busy      (tx_busy),
    .tx_en        (tx_en),
    .tx_data      (tx_data),
    .led_override (led_override),
    .led_value    (led_value),
    .period       (period),
    .err_cnt      (err_cnt),
    .dbg_state_o  (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk_in = ~clk_in;

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- FIFO model ----------------
  logic [7:0] rx_q[$];

  function automatic void fifo_refresh();
    rx_empty = (rx_q.size() == 0);
    rx_data  = rx_empty ? 8'h00 : rx_q[0];
  endfunction

  // ---------------- reference model ----------------
  logic       m_ovr = 1'b0;
  logic [2:0] m_val = 3'd0;
  logic [7:0] m_per = 8'd24;
  logic [7:0] m_err = 8'd0;
  logic [7:0] line_q[$];
  logic [7:0] exp_q[$];
  bit         pend = 1'b0;
  int         n_pop = 0;
  int         n_tx = 0;
  logic       pop_seen, busy_edge, empty_edge;
  logic [7:0] mon_b;

  function automatic int hexval(input logic [7:0] b);
    if (b >= 8'h30 && b <= 8'h39) return int'(b) - 48;
    if (b >= 8'h41 && b <= 8'h46) return int'(b) - 55;
    if (b >= 8'h61 && b <= 8'h66) return int'(b) - 87;
    return -1;
  endfunction

  // Judge one complete non-empty line and apply its effect.
  task automatic eval_line();
    bit         ok;
    int         h1, h2;
    logic [7:0] c;
    ok = 1'b0;
    c  = line_q[0];
    if ((c == 8'h4C || c == 8'h6C) && line_q.size() == 2) begin
      h1 = hexval(line_q[1]);
      if (h1 >= 0 && h1 <= 7) begin
        ok    = 1'b1;
        m_ovr = 1'b1;
        m_val = h1[2:0];
      end
    end else if ((c == 8'h50 || c == 8'h70) && line_q.size() == 3) begin
      h1 = hexval(line_q[1]);
      h2 = hexval(line_q[2]);
      if (h1 >= 0 && h2 >= 0 && (h1 * 16 + h2) != 0) begin
        ok    = 1'b1;
        m_per = 8'(h1 * 16 + h2);
      end
    end else if ((c == 8'h52 || c == 8'h72) && line_q.size() == 1) begin
      ok    = 1'b1;
      m_ovr = 1'b0;
    end
    if (ok) begin
      exp_q.push_back(8'h4B);
    end else begin
      exp_q.push_back(8'h45);
      if (m_err != 8'hFF) m_err = m_err + 8'd1;
    end
  endtask

  always @(posedge clk_in) begin
    pop_seen   <= rx_re;
    busy_edge  <= tx_busy;
    empty_edge <= rx_empty;
  end

  // Scoreboard: reply due at the first edge after the TERM pop with tx_busy low.
  always @(negedge clk_in) begin
    if (!rst_n) begin
      m_ovr = 1'b0;
      m_val = 3'd0;
      m_per = 8'd24;
      m_err = 8'd0;
      line_q.delete();
      exp_q.delete();
      pend = 1'b0;
    end else begin
      if (pend) begin
        chk("pop_in_reply", 32'(pop_seen), 32'd0);
        if (!busy_edge) begin
          chk("tx_en_due", 32'(tx_en), 32'd1);
          if (tx_en) n_tx++;
          if (exp_q.size() != 0) chk("tx_data", 32'(tx_data), 32'(exp_q.pop_front()));
          pend = 1'b0;
        end else begin
          chk("tx_en_busy", 32'(tx_en), 32'd0);
        end
      end else begin
        chk("tx_en_idle", 32'(tx_en), 32'd0);
      end
      if (pop_seen) begin
        chk("pop_nonempty", 32'(empty_edge), 32'd0);
        if (rx_q.size() != 0) begin
          mon_b = rx_q.pop_front();
          n_pop++;
          fifo_refresh();
          if (mon_b == 8'h0A || mon_b == 8'h0D) begin
            if (line_q.size() != 0) begin
              eval_line();
              line_q.delete();
              pend = 1'b1;
            end
          end else begin
            line_q.push_back(mon_b);
          end
        end
      end
      chk("led_override", 32'(led_override), 32'(m_ovr));
      chk("led_value", 32'(led_value), 32'(m_val));
      chk("period", 32'(period), 32'(m_per));
      chk("err_cnt", 32'(err_cnt), 32'(m_err));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk_in);
    #2;
  endtask

  task automatic send(input string body, input logic [7:0] term);
    for (int i = 0; i < body.len(); i++) rx_q.push_back(body[i]);
    rx_q.push_back(term);
    fifo_refresh();
  endtask

  task automatic drain(input int budget, input bit rand_busy);
    int k;
    k = 0;
    while ((rx_q.size() != 0 || pend) && k < budget) begin
      if (rand_busy) tx_busy = ($urandom_range(0, 2) == 0);
      step();
      k++;
    end
    tx_busy = 1'b0;
    while (pend && k < budget + 20) begin
      step();
      k++;
    end
    chk("drain_done", 32'(rx_q.size() == 0 && !pend), 32'd1);
    step();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rx_re"}, 32'(rx_re), 32'd0);
    chk({tag, "_tx_en"}, 32'(tx_en), 32'd0);
    chk({tag, "_tx_data"}, 32'(tx_data), 32'h00);
    chk({tag, "_led_ovr"}, 32'(led_override), 32'd0);
    chk({tag, "_led_val"}, 32'(led_value), 32'd0);
    chk({tag, "_period"}, 32'(period), 32'd24);
    chk({tag, "_err"}, 32'(err_cnt), 32'd0);
  endtask

  function automatic logic [7:0] hexchar(input int v, input bit up);
    if (v < 10) return 8'(8'h30 + v);
    return 8'((up ? 8'h41 : 8'h61) + v - 10);
  endfunction

  function automatic logic [7:0] letter(input logic [7:0] lc);
    return ($urandom_range(0, 1) == 1) ? (lc & 8'hDF) : lc;
  endfunction

  task automatic send_random_line();
    int kind, n;
    kind = $urandom_range(0, 7);
    case (kind)
      0: begin rx_q.push_back(letter(8'h6C)); rx_q.push_back(hexchar($urandom_range(0, 7), 1'($urandom_range(0, 1)))); end
      1: begin rx_q.push_back(letter(8'h6C)); rx_q.push_back(hexchar($urandom_range(8, 15), 1'($urandom_range(0, 1)))); end
      2: begin
        rx_q.push_back(letter(8'h70));
        rx_q.push_back(hexchar($urandom_range(0, 15), 1'($urandom_range(0, 1))));
        rx_q.push_back(hexchar($urandom_range(0, 15), 1'($urandom_range(0, 1))));
      end
      3: begin rx_q.push_back(letter(8'h70)); rx_q.push_back(8'h30); rx_q.push_back(8'h30); end
      4: rx_q.push_back(letter(8'h72));
      5: begin rx_q.push_back(letter(8'h72)); rx_q.push_back(8'($urandom_range(0, 255))); end
      6: begin
        n = $urandom_range(0, 3);
        for (int i = 0; i < n; i++) rx_q.push_back(8'($urandom_range(0, 255)));
      end
      default: rx_q.push_back(letter(8'h6C));
    endcase
    case ($urandom_range(0, 2))
      0: rx_q.push_back(8'h0A);
      1: rx_q.push_back(8'h0D);
      default: begin rx_q.push_back(8'h0D); rx_q.push_back(8'h0A); end
    endcase
    fifo_refresh();
  endtask

  // ---------------- stimulus ----------------
  int t0, p0;

  initial begin
    fifo_refresh();
    repeat (3) step();
    chk_reset_vals("rst");
    rst_n = 1'b1;
    step();

    // L5
    t0 = n_tx;
    send("L5", 8'h0A);
    drain(50, 1'b0);
    chk("l5_ovr", 32'(led_override), 32'd1);
    chk("l5_val", 32'(led_value), 32'd5);
    chk("l5_ntx", 32'(n_tx - t0), 32'd1);
    chk("l5_txd", 32'(tx_data), 32'h4B);
    chk("l5_err", 32'(err_cnt), 32'd0);

    // p3C CRLF: one reply only
    t0 = n_tx;
    send("p3C", 8'h0D);
    send("", 8'h0A);
    drain(50, 1'b0);
    chk("p3c_period", 32'(period), 32'h3C);
    chk("p3c_ntx", 32'(n_tx - t0), 32'd1);
    chk("p3c_txd", 32'(tx_data), 32'h4B);

    // three rejected commands
    t0 = n_tx;
    send("L9", 8'h0A);
    send("PZ1", 8'h0A);
    send("P00", 8'h0A);
    drain(100, 1'b0);
    chk("nak3_ntx", 32'(n_tx - t0), 32'd3);
    chk("nak3_err", 32'(err_cnt), 32'd3);
    chk("nak3_ovr", 32'(led_override), 32'd1);
    chk("nak3_val", 32'(led_value), 32'd5);
    chk("nak3_period", 32'(period), 32'h3C);
    chk("nak3_txd", 32'(tx_data), 32'h45);

    // reply held off by a busy transmitter
    tx_busy = 1'b1;
    t0 = n_tx;
    p0 = n_pop;
    send("R", 8'h0A);
    send("X", 8'h0A);
    repeat (100) step();
    chk("hold_pops", 32'(n_pop - p0), 32'd2);
    chk("hold_ntx", 32'(n_tx - t0), 32'd0);
    tx_busy = 1'b0;
    step();
    chk("hold_release_en", 32'(tx_en), 32'd1);
    chk("hold_release_txd", 32'(tx_data), 32'h4B);
    drain(50, 1'b0);
    chk("hold_ovr", 32'(led_override), 32'd0);
    chk("hold_ntx2", 32'(n_tx - t0), 32'd2);
    chk("hold_err", 32'(err_cnt), 32'd4);

    // reset in the middle of a P command
    t0 = n_tx;
    rx_q.push_back(8'h50);
    rx_q.push_back(8'h34);
    fifo_refresh();
    drain(20, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    step();
    step();
    chk("midrst_ntx", 32'(n_tx - t0), 32'd0);
    rst_n = 1'b1;
    step();
    t0 = n_tx;
    send("P10", 8'h0A);
    drain(50, 1'b0);
    chk("p10_period", 32'(period), 32'h10);
    chk("p10_ntx", 32'(n_tx - t0), 32'd1);
    chk("p10_txd", 32'(tx_data), 32'h4B);
    chk("p10_err", 32'(err_cnt), 32'd0);

    // random command lines with a randomly busy transmitter
    for (int i = 0; i < 150; i++) begin
      send_random_line();
      drain(300, 1'b1);
    end

    // saturation of the error counter
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    t0 = n_tx;
    for (int i = 0; i < 256; i++) send("X", 8'h0A);
    drain(4000, 1'b0);
    chk("sat_err", 32'(err_cnt), 32'hFF);
    chk("sat_ntx", 32'(n_tx - t0), 32'd256);
    chk("sat_txd", 32'(tx_data), 32'h45);

    chk("exp_q_left", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
